// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and constants: controller states, memory
// timeout default, performance counter width and a saturating increment.
package pipe_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 16;
    localparam int          STALL_CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } pipe_state_e;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        return (&v) ? v : v + STALL_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect (
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    input  logic       id_uses_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_memread_i,
    output logic       load_use_o
);

    logic rs1_match;
    logic rs2_match;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency
    always_comb begin
        rs1_match  = (ex_rd_i == id_rs1_i);
        rs2_match  = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
        load_use_o = ex_memread_i && (ex_rd_i != 5'd0) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: data-memory wait freeze with timeout abort,
// branch flush, load-use stall and a saturating stall-cycle counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_RUN  | normal flow; branch flush / load-use stall evaluated
// ST_WAIT | data memory access outstanding, whole pipe frozen
// ST_HALT | memory timeout hit, pipe frozen until reset
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_memread,
    input  logic                   ex_branch_taken,
    input  logic                   mem_req,
    input  logic                   dmem_ack,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   memwb_bubble,
    output logic                   halted,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    pipe_state_e             state_q, state_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d, wait_inc;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic                    mem_err_q, mem_err_d;
    logic                    halted_q, halted_d;
    logic                    freeze;
    logic                    load_use;

    hazard_detect u_hazard (
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_uses_rs2_i (id_uses_rs2),
        .ex_rd_i       (ex_rd),
        .ex_memread_i  (ex_memread),
        .load_use_o    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = 1'b0;
        freeze     = 1'b0;
        wait_inc   = wait_cnt_q + WAIT_W'(1);

        case (state_q)
            ST_RUN: begin
                if (mem_req && !dmem_ack) begin
                    freeze     = 1'b1;
                    wait_cnt_d = WAIT_W'(1);
                    if (WAIT_W'(1) == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d   = ST_HALT;
                        mem_err_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!dmem_ack) begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_inc;
                    if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
                        state_d   = ST_HALT;
                        mem_err_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    // Branch beats load-use: the stalled ID instruction is being discarded anyway
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;

        if (state_q == ST_HALT) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (freeze) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (state_q != ST_HALT)) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    assign halted    = halted_q;
    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues hand-computed expectations
// per cycle, an independent monitor samples the DUT mid-cycle and compares.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic        id_uses_rs2 = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
    logic        mem_req = 1'b0, dmem_ack = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, memwb_bubble;
    logic        halted, mem_err;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic [15:0] id;
        logic [3:0]  en;
        logic [2:0]  fl;
        logic        halt;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    pipe_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rd           (ex_rd),
        .ex_memread      (ex_memread),
        .ex_branch_taken (ex_branch_taken),
        .mem_req         (mem_req),
        .dmem_ack        (dmem_ack),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .memwb_bubble    (memwb_bubble),
        .halted          (halted),
        .mem_err         (mem_err),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    // en = {pc,ifid,idex,exmem}, fl = {ifid_flush,idex_flush,memwb_bubble}
    task automatic step(input int id, input logic rst,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic mr, input logic br,
                        input logic mq, input logic ak,
                        input logic [3:0] en, input logic [2:0] fl,
                        input logic h, input logic e, input logic [15:0] cnt);
        exp_t x;
        @(negedge clk);
        rst_n           = rst;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_uses_rs2     = u2;
        ex_rd           = rd;
        ex_memread      = mr;
        ex_branch_taken = br;
        mem_req         = mq;
        dmem_ack        = ak;
        x.id   = 16'(id);
        x.en   = en;
        x.fl   = fl;
        x.halt = h;
        x.err  = e;
        x.cnt  = cnt;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string name, input logic [15:0] id,
                       input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec%0d: got %h expected %h", name, id, act, req);
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("enables", x.id, 16'({pc_en, ifid_en, idex_en, exmem_en}), 16'(x.en));
                chk("flushes", x.id, 16'({ifid_flush, idex_flush, memwb_bubble}), 16'(x.fl));
                chk("halt_err", x.id, 16'({halted, mem_err}), 16'({x.halt, x.err}));
                chk("stall_cnt", x.id, stall_cnt, x.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // id rst rs1 rs2 u2 rd mr br mq ak | en fl h e cnt
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd0);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd0);
        step(2, 1, 5, 0, 0, 5, 1, 0, 0, 0, 4'b0011, 3'b010, 0, 0, 16'd0);
        step(3, 1, 5, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd1);
        step(4, 1, 3, 7, 1, 7, 1, 0, 0, 0, 4'b0011, 3'b010, 0, 0, 16'd1);
        step(5, 1, 3, 7, 0, 7, 1, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd2);
        step(6, 1, 0, 0, 0, 0, 1, 1, 0, 0, 4'b1111, 3'b110, 0, 0, 16'd2);
        step(7, 1, 5, 0, 0, 5, 1, 1, 0, 0, 4'b1111, 3'b110, 0, 0, 16'd2);
        step(8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd2);
        // memory wait, ack after three frozen cycles
        step(9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd2);
        step(10, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd3);
        step(11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd4);
        step(12, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 3'b000, 0, 0, 16'd5);
        step(13, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 3'b000, 0, 0, 16'd5);
        step(14, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd5);
        // branch held during a two-cycle wait
        step(15, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd5);
        step(16, 1, 0, 0, 0, 0, 0, 1, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd6);
        step(17, 1, 0, 0, 0, 0, 0, 1, 1, 1, 4'b1111, 3'b110, 0, 0, 16'd7);
        step(18, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd7);
        // load-use held during a one-cycle wait
        step(19, 1, 9, 0, 0, 9, 1, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd7);
        step(20, 1, 9, 0, 0, 9, 1, 0, 1, 1, 4'b0011, 3'b010, 0, 0, 16'd8);
        step(21, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd9);
        // timeout: sixteen unacknowledged cycles
        for (int k = 0; k < 16; k++)
            step(22 + k, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'(9 + k));
        step(38, 1, 0, 0, 0, 0, 0, 1, 1, 1, 4'b0000, 3'b000, 1, 1, 16'd25);
        step(39, 1, 5, 0, 0, 5, 1, 0, 0, 0, 4'b0000, 3'b000, 1, 0, 16'd25);
        step(40, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b000, 1, 0, 16'd25);
        // reset out of HALT, then reset mid-WAIT
        step(41, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd0);
        step(42, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd0);
        step(43, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd0);
        step(44, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'd1);
        step(45, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd0);
        step(46, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 3'b000, 0, 0, 16'd0);
        step(47, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'd0);
        // saturation from a preloaded counter, after the monitor has sampled vec47
        #3;
        dut.stall_cnt_q = 16'hFFFE;
        step(48, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'hFFFE);
        step(49, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'hFFFF);
        step(50, 1, 0, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 3'b001, 0, 0, 16'hFFFF);
        step(51, 1, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1111, 3'b000, 0, 0, 16'hFFFF);
        step(52, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 3'b000, 0, 0, 16'hFFFF);

        repeat (3) @(negedge clk);
        #3;
        chk("scoreboard_drain", 16'd0, 16'(exp_q.size()), 16'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16: consecutive unacknowledged data-memory cycles allowed before abort.
REQ-002 SHALL have port clk  in  1  sole clock; every register updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-004 SHALL have ports id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 SHALL have port id_uses_rs2  in  1  ID instruction reads rs2 (R-type, SW, branch).
REQ-006 SHALL have ports ex_rd  in  5 and ex_memread  in  1  destination register and load flag of the instruction in EX.
REQ-007 SHALL have port ex_branch_taken  in  1  branch or JAL in EX resolved taken.
REQ-008 SHALL have ports mem_req  in  1 and dmem_ack  in  1  MEM stage accesses data memory; memory completes the access.
REQ-009 SHALL have ports pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage-register load enables.
REQ-010 SHALL have ports ifid_flush, idex_flush, memwb_bubble  out  1 each  insert a NOP into that stage register.
REQ-011 SHALL have ports halted  out  1, mem_err  out  1, stall_cnt  out  16  status outputs.

Function
REQ-012 SHALL implement FSM states RUN, WAIT and HALT, encoded in the shared package.
REQ-013 In RUN, with mem_req=1 and dmem_ack=0, SHALL drive all enables low and memwb_bubble=1 in that cycle, go to WAIT and set the wait counter to 1.
REQ-014 In RUN or WAIT, mem_req=1 with dmem_ack=1 SHALL count as a completed access: zero-wait, no freeze.
REQ-015 In WAIT, while dmem_ack=0, SHALL hold the freeze of REQ-013 and increment the wait counter.
REQ-016 In WAIT, on dmem_ack=1, SHALL release the freeze in that cycle (all enables high) and return to RUN.
REQ-017 When the wait counter reaches MEM_TIMEOUT with dmem_ack=0, SHALL pulse mem_err for exactly one cycle and enter HALT.
REQ-018 In HALT, SHALL hold all enables 0 and halted=1, and SHALL ignore every input until reset.
REQ-019 In RUN without a memory freeze, ex_branch_taken=1 SHALL assert ifid_flush=1 and idex_flush=1 in the same cycle, with pc_en=1 for the redirect.
REQ-020 In RUN without a memory freeze, a load-use hazard SHALL assert pc_en=0, ifid_en=0 and idex_flush=1 for exactly one cycle.
REQ-021 Load-use hazard definition: ex_memread=1, ex_rd!=0, and either ex_rd==id_rs1 or (id_uses_rs2=1 and ex_rd==id_rs2).
REQ-022 Priority SHALL be: HALT, then memory freeze, then branch flush, then load-use stall.
REQ-023 A branch flush SHALL suppress a simultaneous load-use stall, because the ID instruction is discarded.
REQ-024 A branch or load-use condition that arrives during a freeze SHALL not be lost: EX is frozen, so the condition is acted on in the first unfrozen cycle.
REQ-025 With no event active, all enables SHALL be 1 and all flush/bubble outputs 0.
REQ-026 stall_cnt SHALL increment every cycle in which pc_en=0 and state is not HALT, and SHALL saturate at 16'hFFFF.
REQ-027 Enable, flush and bubble outputs SHALL be combinational from the state and the current inputs; mem_err and halted SHALL be registered.

Reset
REQ-028 While rst_n=0: state=RUN, wait counter=0, stall_cnt=0, mem_err=0, halted=0.
REQ-029 Reset asserted mid-WAIT or in HALT SHALL abort immediately to the values in REQ-028, with no mem_err pulse.
REQ-030 On the first clock edge after rst_n rises, outputs SHALL follow the RUN rules.

Structure
REQ-031 The state enum, the MEM_TIMEOUT default and the stall_cnt width SHALL live in the shared pipeline package.
REQ-032 Hazard detection SHALL be a separate combinational sub-module, hazard_detect, producing load_use.
REQ-033 The FSM, wait counter and perf counter SHALL stay in pipe_ctrl.

Verification
REQ-034 Load-use: ex_memread=1, ex_rd=5, id_rs1=5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; the next cycle has all enables 1.
REQ-035 Branch with x0 hazard: ex_branch_taken=1, ex_memread=1, ex_rd=0 -> ifid_flush=idex_flush=1, pc_en=1, no stall; stall_cnt unchanged.
REQ-036 Memory wait: mem_req=1, dmem_ack rises after 3 cycles -> 3 frozen cycles with memwb_bubble=1, release in the ack cycle, stall_cnt=3.
REQ-037 Timeout: mem_req=1, dmem_ack=0 for 16 cycles -> single mem_err pulse, halted=1 held; asserting rst_n=0 clears both.
REQ-038 Simultaneous events: branch taken during a 2-cycle memory wait -> flushes asserted only in the release cycle.
REQ-039 Saturation: stall_cnt preloaded to 16'hFFFE, then 3 stall cycles -> stall_cnt=16'hFFFF.
